// File: rtl/imem_dmem_port_arbiter_if.sv
// imem_dmem_port_arbiter_if
//   Bundles the fetch requester, data requester and single-port memory
//   signals of the instruction/data memory port arbiter.
//
//   Fetch side : i_req, i_addr -> i_ready ; i_rvalid, i_rdata back
//   Data side  : d_req, d_we, d_addr, d_wdata, d_be -> d_ready ;
//                d_rvalid, d_rdata back (reads only)
//   Memory side: mem_en, mem_we, mem_addr, mem_wdata, mem_be out ;
//                mem_rdata in, valid the cycle after a read issue
//
//   Handshake: a requester raises req with a stable payload and keeps both
//   stable until it sees ready=1 in the same cycle; req && ready in a cycle
//   is the transfer. Dropping req before ready is allowed and issues nothing.
//   Responses are a single-cycle rvalid pulse with no backpressure; rdata
//   keeps its last value afterwards.
//
//   slave  : the arbiter side
//   master : the core/memory side (testbench drives through this view)

interface imem_dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_ready;
    logic                  i_rvalid;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_ready;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_rdata,
        output i_ready, i_rvalid, i_rdata,
        output d_ready, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_rdata,
        input  i_ready, i_rvalid, i_rdata,
        input  d_ready, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// imem_dmem_port_arbiter
//   Shares one single-port synchronous memory (1-cycle read latency)
//   between the instruction-fetch and data requesters. Requests are only
//   accepted in IDLE; a read goes IDLE -> *_WAIT -> IDLE and returns
//   registered data with a one-cycle rvalid two cycles after acceptance.
//   Writes complete in the accept cycle and leave the block in IDLE.
//
// Parameters
//   ADDR_W    address width (must match the interface)
//   DATA_W    data width, multiple of 8 (must match the interface)
//   PRIO_MODE 0 = round-robin on simultaneous requests, 1 = data always wins
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bus         fetch/data/memory signal bundle (slave view)
//   dbg_state_o current FSM state: 0 IDLE, 1 I_WAIT, 2 D_WAIT

module imem_dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    imem_dmem_port_arbiter_if.slave     bus,
    output logic [1:0]                  dbg_state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_I_WAIT = 2'd1;
    localparam logic [1:0] S_D_WAIT = 2'd2;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              grant_i;
    logic              grant_d;

    // Grants only exist in IDLE and never while reset is asserted, so the
    // readies and the memory enable are quiet during reset and WAIT cycles.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst && state_q == S_IDLE) begin
            if (bus.i_req && bus.d_req) begin
                // On a tie the side that did not win last time gets it,
                // unless data is configured as the fixed winner.
                if (PRIO_MODE == 1 || last_grant_q == GNT_FETCH) begin
                    grant_d = 1'b1;
                end else begin
                    grant_i = 1'b1;
                end
            end else begin
                grant_i = bus.i_req;
                grant_d = bus.d_req;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (grant_i) begin
                    state_d      = S_I_WAIT;
                    last_grant_d = GNT_FETCH;
                end else if (grant_d) begin
                    last_grant_d = GNT_DATA;
                    if (!bus.d_we) begin
                        state_d = S_D_WAIT;
                    end
                end
            end
            S_I_WAIT: state_d = S_IDLE;
            S_D_WAIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Memory data is valid in the WAIT cycle; capture it on the way back
    // to IDLE. rdata holds otherwise.
    always_comb begin
        i_rvalid_d = (state_q == S_I_WAIT);
        d_rvalid_d = (state_q == S_D_WAIT);
        i_rdata_d  = (state_q == S_I_WAIT) ? bus.mem_rdata : i_rdata_q;
        d_rdata_d  = (state_q == S_D_WAIT) ? bus.mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_DATA;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.i_ready   = grant_i;
    assign bus.d_ready   = grant_d;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    assign bus.mem_en    = grant_i | grant_d;
    assign bus.mem_we    = grant_d & bus.d_we;
    assign bus.mem_addr  = grant_i ? bus.i_addr : (grant_d ? bus.d_addr : '0);
    assign bus.mem_wdata = grant_d ? bus.d_wdata : '0;
    assign bus.mem_be    = grant_d ? bus.d_be : '0;

    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// tb_imem_dmem_port_arbiter
//   Two arbiters side by side: instance 0 round-robin, instance 1 data
//   priority, each with its own small memory behind it.

module tb_imem_dmem_port_arbiter;

    logic clk;
    logic rst;

    logic [1:0]       s_i_req;
    logic [1:0][31:0] s_i_addr;
    logic [1:0]       s_d_req;
    logic [1:0]       s_d_we;
    logic [1:0][31:0] s_d_addr;
    logic [1:0][31:0] s_d_wdata;
    logic [1:0][3:0]  s_d_be;

    logic [1:0]       o_i_ready, o_d_ready, o_i_rvalid, o_d_rvalid;
    logic [1:0][31:0] o_i_rdata, o_d_rdata;
    logic [1:0]       o_mem_en, o_mem_we;
    logic [1:0][31:0] o_mem_addr, o_mem_wdata;
    logic [1:0][3:0]  o_mem_be;
    logic [1:0][1:0]  o_state;

    int n_checks;
    int n_fail;

    function automatic logic [31:0] init_word(input logic [6:0] j);
        return (j == 7'd16) ? 32'h1234_5678 : (32'hC0DE_0000 | {25'b0, j});
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        imem_dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        imem_dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(k)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .bus         (bus),
            .dbg_state_o (o_state[k])
        );

        assign bus.i_req   = s_i_req[k];
        assign bus.i_addr  = s_i_addr[k];
        assign bus.d_req   = s_d_req[k];
        assign bus.d_we    = s_d_we[k];
        assign bus.d_addr  = s_d_addr[k];
        assign bus.d_wdata = s_d_wdata[k];
        assign bus.d_be    = s_d_be[k];

        assign o_i_ready[k]   = bus.i_ready;
        assign o_d_ready[k]   = bus.d_ready;
        assign o_i_rvalid[k]  = bus.i_rvalid;
        assign o_d_rvalid[k]  = bus.d_rvalid;
        assign o_i_rdata[k]   = bus.i_rdata;
        assign o_d_rdata[k]   = bus.d_rdata;
        assign o_mem_en[k]    = bus.mem_en;
        assign o_mem_we[k]    = bus.mem_we;
        assign o_mem_addr[k]  = bus.mem_addr;
        assign o_mem_wdata[k] = bus.mem_wdata;
        assign o_mem_be[k]    = bus.mem_be;

        // 128-word memory with one-cycle read latency; untouched words read
        // their initial pattern.
        bit [31:0]   env_mem [128];
        bit [127:0]  env_touched;
        logic [31:0] env_rd_q;
        logic [6:0]  env_idx;
        assign env_idx = bus.mem_addr[8:2];

        always @(posedge clk) begin
            if (bus.mem_en) begin
                if (bus.mem_we) begin
                    env_mem[env_idx] <= merge_be(env_touched[env_idx] ? env_mem[env_idx]
                                                                      : init_word(env_idx),
                                                 bus.mem_wdata, bus.mem_be);
                    env_touched[env_idx] <= 1'b1;
                end else begin
                    env_rd_q <= env_touched[env_idx] ? env_mem[env_idx] : init_word(env_idx);
                end
            end
        end
        assign bus.mem_rdata = env_rd_q;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: expected responses with the cycle they are due.
    typedef struct packed {
        int          due;
        bit          is_d;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q [2][$];
    int          m_busy_until [2];
    bit          m_last_d [2];
    logic [31:0] m_mem [2][128];
    logic [31:0] m_i_rd [2];
    logic [31:0] m_d_rd [2];
    bit          m_acc_i [2];
    bit          m_acc_d [2];
    int          mcyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, mcyc, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            resp_t       r;
            bit          e_irv, e_drv, gi, gd, idle;
            logic [31:0] e_ird, e_drd, e_addr, e_wd;
            logic        e_en, e_we;
            logic [3:0]  e_be;

            e_irv = 1'b0;
            e_drv = 1'b0;
            e_ird = m_i_rd[k];
            e_drd = m_d_rd[k];
            if (exp_q[k].size() > 0 && exp_q[k][0].due == mcyc) begin
                r = exp_q[k].pop_front();
                if (r.is_d) begin
                    e_drv     = 1'b1;
                    e_drd     = r.data;
                    m_d_rd[k] = r.data;
                end else begin
                    e_irv     = 1'b1;
                    e_ird     = r.data;
                    m_i_rd[k] = r.data;
                end
            end

            idle = !rst && (mcyc >= m_busy_until[k]);
            gi = 1'b0;
            gd = 1'b0;
            if (idle) begin
                if (s_i_req[k] && s_d_req[k]) gd = (k == 1) || !m_last_d[k];
                else                          gd = s_d_req[k];
                gi = s_i_req[k] && !gd;
            end
            e_en   = gi | gd;
            e_we   = gd & s_d_we[k];
            e_addr = gi ? s_i_addr[k] : (gd ? s_d_addr[k] : 32'h0);
            e_wd   = gd ? s_d_wdata[k] : 32'h0;
            e_be   = gd ? s_d_be[k] : 4'h0;

            chk($sformatf("k%0d_i_ready", k),   o_i_ready[k],   gi);
            chk($sformatf("k%0d_d_ready", k),   o_d_ready[k],   gd);
            chk($sformatf("k%0d_mem_en", k),    o_mem_en[k],    e_en);
            chk($sformatf("k%0d_mem_we", k),    o_mem_we[k],    e_we);
            chk($sformatf("k%0d_mem_addr", k),  o_mem_addr[k],  e_addr);
            chk($sformatf("k%0d_mem_wdata", k), o_mem_wdata[k], e_wd);
            chk($sformatf("k%0d_mem_be", k),    o_mem_be[k],    e_be);
            chk($sformatf("k%0d_i_rvalid", k),  o_i_rvalid[k],  e_irv);
            chk($sformatf("k%0d_i_rdata", k),   o_i_rdata[k],   e_ird);
            chk($sformatf("k%0d_d_rvalid", k),  o_d_rvalid[k],  e_drv);
            chk($sformatf("k%0d_d_rdata", k),   o_d_rdata[k],   e_drd);

            m_acc_i[k] = gi;
            m_acc_d[k] = gd;
            if (rst) begin
                exp_q[k].delete();
                m_busy_until[k] = 0;
                m_last_d[k]     = 1'b1;
                m_i_rd[k]       = 32'h0;
                m_d_rd[k]       = 32'h0;
            end else if (gi) begin
                exp_q[k].push_back('{due: mcyc + 2, is_d: 1'b0,
                                     data: m_mem[k][s_i_addr[k][8:2]]});
                m_busy_until[k] = mcyc + 2;
                m_last_d[k]     = 1'b0;
            end else if (gd) begin
                m_last_d[k] = 1'b1;
                if (s_d_we[k]) begin
                    m_mem[k][s_d_addr[k][8:2]] = merge_be(m_mem[k][s_d_addr[k][8:2]],
                                                          s_d_wdata[k], s_d_be[k]);
                end else begin
                    exp_q[k].push_back('{due: mcyc + 2, is_d: 1'b1,
                                         data: m_mem[k][s_d_addr[k][8:2]]});
                    m_busy_until[k] = mcyc + 2;
                end
            end
        end
        mcyc++;
    endtask

    task automatic end_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            end_cycle();
        end
    endtask

    task automatic set_all(input logic ir, input logic [31:0] ia,
                           input logic dr, input logic dw, input logic [31:0] da,
                           input logic [31:0] dwd, input logic [3:0] dbe);
        for (int k = 0; k < 2; k++) begin
            s_i_req[k]   = ir;
            s_i_addr[k]  = ia;
            s_d_req[k]   = dr;
            s_d_we[k]    = dw;
            s_d_addr[k]  = da;
            s_d_wdata[k] = dwd;
            s_d_be[k]    = dbe;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mcyc     = 0;
        for (int k = 0; k < 2; k++) begin
            m_busy_until[k] = 0;
            m_last_d[k]     = 1'b1;
            m_i_rd[k]       = 32'h0;
            m_d_rd[k]       = 32'h0;
            m_acc_i[k]      = 1'b0;
            m_acc_d[k]      = 1'b0;
            for (int j = 0; j < 128; j++) m_mem[k][j] = init_word(7'(j));
        end
        rst = 1'b1;
        set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        run_cycles(2);
        rst = 1'b0;

        // Single fetch after reset.
        set_all(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("fetch_ready", o_i_ready[0], 1'b1);
        chk("fetch_mem_en", o_mem_en[0], 1'b1);
        chk("fetch_mem_addr", o_mem_addr[0], 32'h40);
        chk("fetch_mem_we", o_mem_we[0], 1'b0);
        end_cycle();
        set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("fetch_rvalid_n1", o_i_rvalid[0], 1'b0);
        end_cycle();
        @(negedge clk);
        chk("fetch_rvalid_n2", o_i_rvalid[0], 1'b1);
        chk("fetch_rdata_n2", o_i_rdata[0], 32'h1234_5678);
        end_cycle();
        @(negedge clk);
        chk("fetch_rvalid_n3", o_i_rvalid[0], 1'b0);
        chk("fetch_rdata_hold", o_i_rdata[0], 32'h1234_5678);
        end_cycle();

        // Back-to-back data writes.
        set_all(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clk);
        chk("wr_ready", o_d_ready[0], 1'b1);
        chk("wr_mem_we", o_mem_we[0], 1'b1);
        chk("wr_mem_be", o_mem_be[0], 4'b0011);
        chk("wr_mem_wdata", o_mem_wdata[0], 32'hDEAD_BEEF);
        end_cycle();
        set_all(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h0BAD_F00D, 4'hF);
        @(negedge clk);
        chk("wr2_ready", o_d_ready[0], 1'b1);
        chk("wr2_state_idle", o_state[0], 2'd0);
        end_cycle();
        set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_cycles(1);

        // Continuous contention from reset; data side reads 0x100.
        rst = 1'b1;
        set_all(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        @(negedge clk);
        chk("rst_i_ready", o_i_ready[0], 1'b0);
        chk("rst_d_ready", o_d_ready[0], 1'b0);
        chk("rst_mem_en", o_mem_en[0], 1'b0);
        end_cycle();
        rst = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk($sformatf("rr_i_ready_t%0d", t), o_i_ready[0], (t % 4) == 0);
            chk($sformatf("rr_d_ready_t%0d", t), o_d_ready[0], (t % 4) == 2);
            chk($sformatf("pri_d_ready_t%0d", t), o_d_ready[1], (t % 2) == 0);
            chk($sformatf("pri_i_ready_t%0d", t), o_i_ready[1], 1'b0);
            if (t == 4) chk("rr_d_rdata", o_d_rdata[0], 32'hC0DE_BEEF);
            if (t == 2) chk("pri_d_rdata", o_d_rdata[1], 32'hC0DE_BEEF);
            end_cycle();
        end

        // Data priority with back-to-back writes.
        rst = 1'b1;
        set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_cycles(1);
        rst = 1'b0;
        set_all(1'b1, 32'h40, 1'b1, 1'b1, 32'h108, 32'h55AA_55AA, 4'hF);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk($sformatf("pw_d_ready_t%0d", t), o_d_ready[1], 1'b1);
            chk($sformatf("pw_i_ready_t%0d", t), o_i_ready[1], 1'b0);
            end_cycle();
        end
        s_d_req[1] = 1'b0;
        s_d_req[0] = 1'b0;
        @(negedge clk);
        chk("pw_fetch_after", o_i_ready[1], 1'b1);
        end_cycle();
        set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_cycles(3);

        // Reset in the middle of a fetch.
        set_all(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("mr_accept", o_i_ready[0], 1'b1);
        end_cycle();
        set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        run_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_no_rvalid", o_i_rvalid[0], 1'b0);
        chk("mr_rdata_zero", o_i_rdata[0], 32'h0);
        chk("mr_state_idle", o_state[0], 2'd0);
        end_cycle();
        set_all(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("mr_refetch", o_i_ready[0], 1'b1);
        end_cycle();
        set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_cycles(1);
        @(negedge clk);
        chk("mr_refetch_rvalid", o_i_rvalid[0], 1'b1);
        chk("mr_refetch_rdata", o_i_rdata[0], 32'h1234_5678);
        end_cycle();

        // Data request raised while a fetch is in flight.
        set_all(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("rw_fetch", o_i_ready[0], 1'b1);
        end_cycle();
        set_all(1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
        @(negedge clk);
        chk("rw_wait_d_ready", o_d_ready[0], 1'b0);
        chk("rw_wait_mem_en", o_mem_en[0], 1'b0);
        end_cycle();
        @(negedge clk);
        chk("rw_idle_d_ready", o_d_ready[0], 1'b1);
        end_cycle();
        set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_cycles(3);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            for (int k = 0; k < 2; k++) begin
                if (s_i_req[k] && !m_acc_i[k]) begin
                    if ($urandom_range(0, 9) == 0) s_i_req[k] = 1'b0;
                end else begin
                    s_i_req[k]  = ($urandom_range(0, 99) < 55);
                    s_i_addr[k] = 32'($urandom_range(0, 127)) << 2;
                end
                if (s_d_req[k] && !m_acc_d[k]) begin
                    if ($urandom_range(0, 9) == 0) s_d_req[k] = 1'b0;
                end else begin
                    s_d_req[k]   = ($urandom_range(0, 99) < 55);
                    s_d_we[k]    = $urandom_range(0, 1);
                    s_d_addr[k]  = 32'($urandom_range(0, 127)) << 2;
                    s_d_wdata[k] = $urandom;
                    s_d_be[k]    = 4'($urandom_range(0, 15));
                end
            end
            run_cycles(1);
        end

        rst = 1'b0;
        set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        run_cycles(4);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("k%0d_drained", k), exp_q[k].size(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
